// File: rtl/lsq_pkg.sv
// Shared LSQ definitions: issue FSM encoding, register-tag width derivation, entry field widths.
package lsq_pkg;

    localparam int unsigned NUM_PHYS_REGS_DEF = 64;
    localparam int unsigned ADDR_W            = 32;
    localparam int unsigned DATA_W            = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WB    = 2'd3
    } issue_state_e;

    // Latched memory request payload for the dispatched head entry
    typedef struct packed {
        logic              store;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Physical register tag width; a single-register file still needs one bit
    function automatic int unsigned log_phys(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lsq_issue_ctrl_if.sv
// LSQ-head, memory and writeback signals of the issue controller; master = controller side.
interface lsq_issue_ctrl_if #(
    parameter int unsigned LOG_PHYS = lsq_pkg::log_phys(lsq_pkg::NUM_PHYS_REGS_DEF)
);
    logic                      Empty_IN;
    logic                      HeadStore_IN;
    logic                      HeadReady_IN;
    logic [LOG_PHYS-1:0]       HeadReg_IN;
    logic [lsq_pkg::ADDR_W-1:0] HeadAddr_IN;
    logic [lsq_pkg::DATA_W-1:0] StoreData_IN;
    logic                      Dequeue_OUT;
    logic                      MemReq_OUT;
    logic                      MemWrite_OUT;
    logic [lsq_pkg::ADDR_W-1:0] MemAddr_OUT;
    logic [lsq_pkg::DATA_W-1:0] MemWData_OUT;
    logic                      MemAck_IN;
    logic [lsq_pkg::DATA_W-1:0] MemRData_IN;
    logic                      WbValid_OUT;
    logic [LOG_PHYS-1:0]       WbReg_OUT;
    logic [lsq_pkg::DATA_W-1:0] WbData_OUT;
    logic                      Busy_OUT;
    logic                      Error_OUT;

    modport master (
        input  Empty_IN, HeadStore_IN, HeadReady_IN, HeadReg_IN, HeadAddr_IN, StoreData_IN,
               MemAck_IN, MemRData_IN,
        output Dequeue_OUT, MemReq_OUT, MemWrite_OUT, MemAddr_OUT, MemWData_OUT,
               WbValid_OUT, WbReg_OUT, WbData_OUT, Busy_OUT, Error_OUT
    );

    modport slave (
        output Empty_IN, HeadStore_IN, HeadReady_IN, HeadReg_IN, HeadAddr_IN, StoreData_IN,
               MemAck_IN, MemRData_IN,
        input  Dequeue_OUT, MemReq_OUT, MemWrite_OUT, MemAddr_OUT, MemWData_OUT,
               WbValid_OUT, WbReg_OUT, WbData_OUT, Busy_OUT, Error_OUT
    );
endinterface

// File: rtl/lsq_issue_timer.sv
// Memory-ack watchdog: counts cycles an access sits in REQ/DRAIN, restarting at each dispatch.
module lsq_issue_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic run_i,
    output logic expire_c
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Expires in the last allowed waiting cycle so the FSM leaves on that edge
    assign expire_c = run_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = '0;
        end else if (run_i && !expire_c) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/lsq_issue_ctrl.sv
// LSQ head issue controller: one memory op at a time, load writeback, flush/drain handling.
// Optional memory-ack watchdog enabled by defining LSQ_ISSUE_TIMEOUT_EN.
module lsq_issue_ctrl
    import lsq_pkg::*;
#(
    parameter int unsigned NUM_PHYS_REGS  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    lsq_issue_ctrl_if.master lsq
);
    localparam int unsigned LOG_PHYS = log_phys(NUM_PHYS_REGS);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    issue_state_e        state_q, state_d;
    mem_req_t            req_q, req_d;
    logic [LOG_PHYS-1:0] wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                error_q, error_d;
    logic                dequeue_c;
    logic                in_mem_c;
    logic                expire_c;

    assign in_mem_c = (state_q == ST_REQ) || (state_q == ST_DRAIN);

`ifdef LSQ_ISSUE_TIMEOUT_EN
    lsq_issue_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (CLK),
        .rst      (RESET),
        .start_i  (dequeue_c),
        .run_i    (in_mem_c),
        .expire_c (expire_c)
    );
`else
    assign expire_c = 1'b0;
`endif

    // Next state; an ack always wins over a same-cycle timeout or flush
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        error_d   = 1'b0;
        dequeue_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!RESET && !lsq.Empty_IN && lsq.HeadReady_IN && !FLUSH) begin
                    dequeue_c = 1'b1;
                    req_d     = '{store: lsq.HeadStore_IN, addr: lsq.HeadAddr_IN,
                                  wdata: lsq.StoreData_IN};
                    wb_reg_d  = lsq.HeadReg_IN;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (lsq.MemAck_IN) begin
                    if (req_q.store || FLUSH) begin
                        state_d = ST_IDLE;
                    end else begin
                        wb_data_d = lsq.MemRData_IN;
                        state_d   = ST_WB;
                    end
                end else if (expire_c) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (FLUSH && !req_q.store) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (lsq.MemAck_IN) begin
                    state_d = ST_IDLE;
                end else if (expire_c) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
            error_q   <= error_d;
        end
    end

    // Dequeue pops the head in the dispatch cycle itself; a flush landing in WB kills the writeback
    assign lsq.Dequeue_OUT  = dequeue_c;
    assign lsq.MemReq_OUT   = in_mem_c;
    assign lsq.MemWrite_OUT = req_q.store;
    assign lsq.MemAddr_OUT  = req_q.addr;
    assign lsq.MemWData_OUT = req_q.wdata;
    assign lsq.WbValid_OUT  = (state_q == ST_WB) && !FLUSH;
    assign lsq.WbReg_OUT    = wb_reg_q;
    assign lsq.WbData_OUT   = wb_data_q;
    assign lsq.Busy_OUT     = (state_q != ST_IDLE);
    assign lsq.Error_OUT    = error_q;
endmodule

// File: tb/tb_lsq_issue_ctrl.sv
// Bench for lsq_issue_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_lsq_issue_ctrl;
    localparam int unsigned NPR = 64;
    localparam int unsigned LP  = $clog2(NPR);
    localparam int unsigned TMO = 8;

    typedef struct {
        logic          rst;
        logic          flush;
        logic          empty;
        logic          store;
        logic          ready;
        logic [LP-1:0] rg;
        logic [31:0]   addr;
        logic [31:0]   sdata;
        logic          ack;
        logic [31:0]   rdata;
    } stim_t;

    logic clk;
    logic rst;
    logic flush;

    lsq_issue_ctrl_if #(.LOG_PHYS(LP)) bus ();

    lsq_issue_ctrl #(
        .NUM_PHYS_REGS  (NPR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .FLUSH (flush),
        .lsq   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Model: one outstanding access and a possibly owed writeback
    bit            m_active, m_store, m_drain, m_wb, m_err;
    logic [31:0]   m_addr, m_wdata, m_rdata;
    logic [LP-1:0] m_reg;
    int            m_elapsed;

    logic          o_deq, o_req, o_write, o_wbv, o_busy, o_error;
    logic [31:0]   o_addr, o_wdata, o_wbdata;
    logic [LP-1:0] o_wbreg;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst = 1'b0; s.flush = 1'b0; s.empty = 1'b1; s.store = 1'b0; s.ready = 1'b0;
        s.rg = '0; s.addr = '0; s.sdata = '0; s.ack = 1'b0; s.rdata = '0;
        return s;
    endfunction

    function automatic stim_t head_stim(input logic st, input logic [LP-1:0] rg,
                                        input logic [31:0] a, input logic [31:0] d);
        stim_t s;
        s = idle_stim();
        s.empty = 1'b0; s.ready = 1'b1; s.store = st; s.rg = rg; s.addr = a; s.sdata = d;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst   = ($urandom_range(199) == 0);
        s.flush = ($urandom_range(7) == 0);
        s.empty = ($urandom_range(3) == 0);
        s.ready = ($urandom_range(2) != 0);
        s.store = $urandom_range(1) == 1;
        s.rg    = LP'($urandom);
        s.addr  = $urandom;
        s.sdata = $urandom;
        s.ack   = ($urandom_range(2) == 0);
        s.rdata = $urandom;
        return s;
    endfunction

    task automatic compare_model(input stim_t s);
        logic exp_deq;
        exp_deq = !s.rst && !m_active && !m_wb && !s.empty && s.ready && !s.flush;
        check_eq("dequeue", o_deq, exp_deq);
        check_eq("mem_req", o_req, m_active);
        if (m_active) begin
            check_eq("mem_addr", o_addr, m_addr);
            check_eq("mem_write", o_write, m_store);
            if (m_store) check_eq("mem_wdata", o_wdata, m_wdata);
        end
        check_eq("wb_valid", o_wbv, m_wb && !s.flush);
        if (m_wb && !s.flush) begin
            check_eq("wb_reg", o_wbreg, m_reg);
            check_eq("wb_data", o_wbdata, m_rdata);
        end
        check_eq("busy", o_busy, m_active || m_wb);
        check_eq("error", o_error, m_err);
    endtask

    task automatic update_model(input stim_t s);
        bit timed_out;
        m_err = 1'b0;
        if (s.rst) begin
            m_active = 1'b0; m_wb = 1'b0; m_drain = 1'b0;
        end else if (m_active) begin
`ifdef LSQ_ISSUE_TIMEOUT_EN
            timed_out = (m_elapsed + 1 >= int'(TMO));
`else
            timed_out = 1'b0;
`endif
            if (s.ack) begin
                m_active = 1'b0;
                if (!m_store && !m_drain && !s.flush) m_wb = 1'b1;
                m_rdata = s.rdata;
            end else if (timed_out) begin
                m_active = 1'b0;
                m_err = 1'b1;
            end else begin
                if (!m_store && s.flush) m_drain = 1'b1;
                m_elapsed++;
            end
        end else if (m_wb) begin
            m_wb = 1'b0;
        end else if (!s.empty && s.ready && !s.flush) begin
            m_active = 1'b1; m_drain = 1'b0; m_elapsed = 0;
            m_store = s.store; m_addr = s.addr; m_wdata = s.sdata; m_reg = s.rg;
        end
    endtask

    task automatic step(input stim_t s);
        @(negedge clk);
        rst = s.rst;
        flush = s.flush;
        bus.Empty_IN     = s.empty;
        bus.HeadStore_IN = s.store;
        bus.HeadReady_IN = s.ready;
        bus.HeadReg_IN   = s.rg;
        bus.HeadAddr_IN  = s.addr;
        bus.StoreData_IN = s.sdata;
        bus.MemAck_IN    = s.ack;
        bus.MemRData_IN  = s.rdata;
        #1;
        o_deq = bus.Dequeue_OUT;   o_req = bus.MemReq_OUT;     o_write = bus.MemWrite_OUT;
        o_addr = bus.MemAddr_OUT;  o_wdata = bus.MemWData_OUT; o_wbv = bus.WbValid_OUT;
        o_wbreg = bus.WbReg_OUT;   o_wbdata = bus.WbData_OUT;  o_busy = bus.Busy_OUT;
        o_error = bus.Error_OUT;
        compare_model(s);
        @(posedge clk);
        update_model(s);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle_stim();
        s.rst = 1'b1;
        step(s);
        step(s);
    endtask

    initial begin
        stim_t s;
        int    wb_seen;
        int    err_seen;
        int    err_at;

        rst = 1'b1; flush = 1'b0;
        bus.Empty_IN = 1'b1; bus.HeadStore_IN = 1'b0; bus.HeadReady_IN = 1'b0;
        bus.HeadReg_IN = '0; bus.HeadAddr_IN = '0; bus.StoreData_IN = '0;
        bus.MemAck_IN = 1'b0; bus.MemRData_IN = '0;
        m_active = 0; m_store = 0; m_drain = 0; m_wb = 0; m_err = 0; m_elapsed = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_reg = '0;

        do_reset();
        step(idle_stim());
        check_eq("rst_req", o_req, 1'b0);
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_wbv", o_wbv, 1'b0);
        check_eq("rst_err", o_error, 1'b0);

        // Minimum-latency load
        step(head_stim(1'b0, LP'(5), 32'h100, 32'h0));
        check_eq("ld_deq_c0", o_deq, 1'b1);
        s = idle_stim(); s.ack = 1'b1; s.rdata = 32'hDEADBEEF;
        step(s);
        check_eq("ld_req_c1", o_req, 1'b1);
        check_eq("ld_addr_c1", o_addr, 32'h100);
        step(idle_stim());
        check_eq("ld_wbv_c2", o_wbv, 1'b1);
        check_eq("ld_wbreg_c2", o_wbreg, 32'd5);
        check_eq("ld_wbdata_c2", o_wbdata, 32'hDEADBEEF);
        step(idle_stim());
        check_eq("ld_wbv_c3", o_wbv, 1'b0);

        // Store with ack delayed four cycles
        wb_seen = 0;
        step(head_stim(1'b1, LP'(9), 32'h200, 32'h12345678));
        check_eq("st_deq", o_deq, 1'b1);
        for (int i = 0; i < 5; i++) begin
            s = idle_stim(); s.ack = (i == 4);
            step(s);
            check_eq("st_req_held", o_req, 1'b1);
            check_eq("st_write", o_write, 1'b1);
            check_eq("st_addr", o_addr, 32'h200);
            check_eq("st_wdata", o_wdata, 32'h12345678);
            wb_seen += int'(o_wbv);
        end
        step(idle_stim());
        wb_seen += int'(o_wbv);
        check_eq("st_done_busy", o_busy, 1'b0);
        check_eq("st_no_wb", wb_seen, 0);

        // Flushed load drains without writeback
        wb_seen = 0;
        step(head_stim(1'b0, LP'(7), 32'h300, 32'h0));
        s = idle_stim(); s.flush = 1'b1;
        step(s);
        step(idle_stim());
        check_eq("drain_req", o_req, 1'b1);
        wb_seen += int'(o_wbv);
        s = idle_stim(); s.ack = 1'b1; s.rdata = 32'hCAFE0000;
        step(s);
        check_eq("drain_req_ack", o_req, 1'b1);
        step(idle_stim());
        wb_seen += int'(o_wbv);
        check_eq("drain_idle", o_busy, 1'b0);
        check_eq("drain_no_wb", wb_seen, 0);

        // Head not ready for ten cycles, then dispatch on the rising cycle
        for (int i = 0; i < 10; i++) begin
            s = head_stim(1'b0, LP'(3), 32'h400, 32'h0); s.ready = 1'b0;
            step(s);
            check_eq("nr_no_deq", o_deq, 1'b0);
        end
        step(head_stim(1'b0, LP'(3), 32'h400, 32'h0));
        check_eq("nr_deq_rise", o_deq, 1'b1);
        s = idle_stim(); s.ack = 1'b1; s.rdata = 32'h0BADF00D;
        step(s);
        step(idle_stim());
        check_eq("nr_wbdata", o_wbdata, 32'h0BADF00D);

        // Reset mid-request abandons the access
        step(head_stim(1'b0, LP'(11), 32'h500, 32'h55AA55AA));
        s = idle_stim(); s.rst = 1'b1;
        step(s);
        step(idle_stim());
        check_eq("mid_rst_req", o_req, 1'b0);
        check_eq("mid_rst_write", o_write, 1'b0);
        check_eq("mid_rst_addr", o_addr, 32'h0);
        check_eq("mid_rst_wdata", o_wdata, 32'h0);
        check_eq("mid_rst_wbreg", o_wbreg, 32'h0);
        check_eq("mid_rst_wbdata", o_wbdata, 32'h0);
        check_eq("mid_rst_busy", o_busy, 1'b0);
        step(idle_stim());
        check_eq("mid_rst_no_retry", o_req, 1'b0);

`ifdef LSQ_ISSUE_TIMEOUT_EN
        // Watchdog: no ack at all
        err_seen = 0; err_at = -1;
        step(head_stim(1'b0, LP'(2), 32'h600, 32'h0));
        for (int i = 0; i < 12; i++) begin
            step(idle_stim());
            if (o_error) begin
                err_seen++;
                if (err_at < 0) err_at = i;
            end
            if (i >= int'(TMO)) check_eq("tmo_req_dropped", o_req, 1'b0);
        end
        check_eq("tmo_err_count", err_seen, 1);
        check_eq("tmo_err_cycle", err_at, TMO);
`else
        err_seen = 0; err_at = -1;
        step(head_stim(1'b0, LP'(2), 32'h600, 32'h0));
        for (int i = 0; i < 20; i++) begin
            step(idle_stim());
            err_seen += int'(o_error);
        end
        check_eq("wait_req_held", o_req, 1'b1);
        check_eq("wait_no_err", err_seen, 0);
        s = idle_stim(); s.ack = 1'b1;
        step(s);
        step(idle_stim());
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(rand_stim());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
